overlap_add: RTL
================

Name: overlap_add

Overview:
- Inverse of the framing/windowing stage: consumes a stream of windowed frames (FRAME_SIZE samples each, frames advanced by HOP_SIZE) and reconstructs a continuous audio sample stream by overlap-add.
- Sits on the resynthesis/loopback path after framing, where it is used for round-trip checks of the front end.
- Input is a valid/ready sample stream. Output is a valid/ready sample stream with backpressure.

Parameters:
- FRAME_SIZE, 8, samples per input frame.
- HOP_SIZE, 4, frame advance in samples. FRAME_SIZE must be a multiple of HOP_SIZE, and FRAME_SIZE/HOP_SIZE ≤ 4.
- DATA_WIDTH, 16, signed two's-complement sample width (in and out).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising edge of clk).
- frame_in  in  DATA_WIDTH  signed windowed sample; frame order, index 0..FRAME_SIZE-1.
- valid_in  in  1  frame_in valid.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  level request: emit the remaining tail at end of stream.
- audio_out  out  DATA_WIDTH  signed reconstructed sample.
- valid_out  out  1  audio_out valid.
- out_ready  in  1  downstream accepts audio_out.
- flush_done  out  1  one-cycle pulse when the flush tail is fully emitted.
- drop_err  out  1  sticky; set when valid_in is high while in_ready is low.

Behaviour:
- Storage
  - Accumulator array acc[0..FRAME_SIZE-1], each ACC_W = DATA_WIDTH+2 bits signed.
  - Sample index idx counts 0..FRAME_SIZE-1.
  - Emit counter cnt.
- States
  - ACCUM: in_ready=1.
  - EMIT: in_ready=0.
  - FLUSH: in_ready=0.
- Reset (rst==0 at an edge)
  - State=ACCUM; acc all 0; idx=0; cnt=0.
  - valid_out=0, audio_out=0, flush_done=0, drop_err=0.
  - in_ready is forced 0 while rst==0.
  - Reset mid-EMIT or mid-FLUSH discards all buffered data.
- ACCUM
  - On valid_in&&in_ready: acc[idx] <= acc[idx] + sign-extended frame_in, and idx increments.
  - When idx==FRAME_SIZE-1 is accepted: idx<=0, cnt<=0, next state=EMIT.
  - If flush==1 && idx==0 && valid_in==0: cnt<=0, next state=FLUSH.
  - valid_in wins over flush. flush is ignored while idx≠0; the requester holds flush until flush_done.
- EMIT
  - valid_out=1; audio_out=sat(acc[0]).
  - On valid_out&&out_ready:
    - shift acc[i]<=acc[i+1] for i<FRAME_SIZE-1;
    - acc[FRAME_SIZE-1]<=0;
    - cnt++.
  - After HOP_SIZE handshakes, return to ACCUM.
  - With out_ready low, audio_out and valid_out hold stable.
- FLUSH
  - Same output/shift mechanics as EMIT, for FRAME_SIZE-HOP_SIZE handshakes.
  - Then flush_done pulses for 1 cycle and state=ACCUM; buffer is all zero at that point.
- Outputs
  - valid_out, audio_out and flush_done are decoded from registered state/acc only; no combinational path from any input to them.
  - audio_out=0 whenever valid_out=0.
- Latency
  - The last sample of a frame is accepted at edge t; valid_out is high in the cycle after edge t.
  - Throughput per frame is FRAME_SIZE input cycles + HOP_SIZE output handshakes.
- Arithmetic
  - Accumulation is full precision in ACC_W; no wrap is possible within the parameter limits.
  - sat() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Errors
  - valid_in high while in_ready=0 sets drop_err. The sample is dropped and acc is unchanged.
  - drop_err clears only on reset.

Test Plan:
1. Defaults. Frame 1 = eight samples of 100, out_ready=1 → four outputs of 100, valid_out first high 1 cycle after the 8th accept. Frame 2 = eight × 100 → four outputs of 200.
2. After frame 2, hold flush=1 with valid_in=0 → four outputs of 100. Then flush_done pulses once, in_ready returns to 1, and a new frame of 5s yields four outputs of 5.
3. Saturation. Two frames of 30000 → second emit gives 32767 ×4. Two frames of -30000 → second emit gives -32768 ×4.
4. Backpressure. out_ready=0 for 5 cycles during EMIT → valid_out=1 and audio_out stable; no shift occurs; output sequence is unchanged after release.
5. Overrun. valid_in=1 with frame_in=7 during EMIT → drop_err=1 and the sample is not accumulated. flush asserted at idx=3 → ignored, state stays ACCUM.
6. Reset mid-EMIT. Assert rst=0 after 2 of 4 outputs → next cycle valid_out=0 and audio_out=0. After release, a frame of 1s emits four outputs of 1 (no stale data).

Source files
------------

// File: rtl/overlap_add.sv
// Overlap-add resynthesis: accumulates windowed frames into a sliding buffer and emits HOP_SIZE
// saturated samples per frame; a flush request drains the remaining tail at end of stream.
module overlap_add #(
  parameter int FRAME_SIZE = 8,
  parameter int HOP_SIZE   = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] frame_in,
  input  logic                  valid_in,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] audio_out,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic                  flush_done,
  output logic                  drop_err
);

  localparam int ACC_W = DATA_WIDTH + 2;
  localparam int IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int CNT_W = $clog2(FRAME_SIZE + 1);
  localparam int TAIL  = FRAME_SIZE - HOP_SIZE;

  typedef enum logic [1:0] {ACCUM, EMIT, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic signed [ACC_W-1:0]   acc [FRAME_SIZE];
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          cnt;
  logic                      hs;
  logic                      accept;
  logic                      last_in;
  logic                      flush_go;
  logic                      emit_last;
  logic                      flush_last;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    if (a[ACC_W-1] && !(&a[ACC_W-2:DATA_WIDTH-1]))
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else if (!a[ACC_W-1] && (|a[ACC_W-2:DATA_WIDTH-1]))
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      r = a[DATA_WIDTH-1:0];
    return r;
  endfunction

  assign hs         = valid_out && out_ready;
  assign accept     = valid_in && in_ready;
  assign last_in    = (idx == IDX_W'(FRAME_SIZE - 1));
  // flush_done is still high in the first ACCUM cycle while the requester holds flush;
  // ignoring flush then keeps the finished request from starting a second drain.
  assign flush_go   = flush && (idx == '0) && !valid_in && !flush_done;
  assign emit_last  = hs && (cnt == CNT_W'(HOP_SIZE - 1));
  assign flush_last = hs && (cnt == CNT_W'(TAIL - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: begin
        if (accept && last_in) state_nxt = EMIT;
        else if (flush_go)     state_nxt = FLUSH;
      end
      EMIT:    if (emit_last)  state_nxt = ACCUM;
      FLUSH:   if (flush_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state == ACCUM);
    valid_out = (state == EMIT) || (state == FLUSH);
    audio_out = valid_out ? sat(acc[0]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FRAME_SIZE; i++) acc[i] <= '0;
      idx        <= '0;
      cnt        <= '0;
      flush_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      flush_done <= (state == FLUSH) && flush_last;
      if (valid_in && !in_ready) drop_err <= 1'b1;
      case (state)
        ACCUM: begin
          if (accept) begin
            acc[idx] <= acc[idx] + {{(ACC_W-DATA_WIDTH){frame_in[DATA_WIDTH-1]}}, frame_in};
            if (last_in) begin
              idx <= '0;
              cnt <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else if (flush_go) begin
            cnt <= '0;
          end
        end
        EMIT, FLUSH: begin
          if (hs) begin
            for (int i = 0; i < FRAME_SIZE - 1; i++) acc[i] <= acc[i+1];
            acc[FRAME_SIZE-1] <= '0;
            cnt               <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
